// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the hazard scoreboard.
// Contents:
// - register-file geometry;
// - the layout of one shadow-pipeline entry, {valid, dest, regwrite, memread};
// - the bubble entry;
// - a helper that tests whether an entry writes a given register.
package hazard_scoreboard_pkg;

  localparam int unsigned SbAddrW   = 2;
  localparam int unsigned SbNumRegs = 4;

  // Entry bit layout, MSB to LSB: valid | dest[SbAddrW-1:0] | regwrite | memread
  localparam int unsigned SbMrBit    = 0;
  localparam int unsigned SbRwBit    = 1;
  localparam int unsigned SbDestLsb  = 2;
  localparam int unsigned SbValidBit = SbDestLsb + SbAddrW;
  localparam int unsigned SbEntryW   = SbValidBit + 1;

  localparam logic [SbEntryW-1:0] SbBubble = '0;

  function automatic logic sb_writes(logic [SbEntryW-1:0] e, logic [SbAddrW-1:0] r);
    return e[SbValidBit] & e[SbRwBit] & (e[SbDestLsb +: SbAddrW] == r);
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow-pipeline entry.
// Ports:
// - clk_i, rst_ni: clock and asynchronous active-low reset (clears the entry).
// - en_i: advance; when low the entry holds.
// - bubble_i: when advancing, load the all-zero bubble instead of d_i.
// - d_i / q_o: next entry / current entry.
module hazard_stage_reg
  import hazard_scoreboard_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                bubble_i,
  input  logic [SbEntryW-1:0] d_i,
  output logic [SbEntryW-1:0] q_o
);

  logic [SbEntryW-1:0] entry_d, entry_q;

  always_comb begin
    entry_d = entry_q;
    if (en_i) begin
      entry_d = bubble_i ? SbBubble : d_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry_q <= SbBubble;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign q_o = entry_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard for the 5-stage CPU.
// Shadows every in-flight register write in EX, MEM and WB. It stalls IF/ID and
// bubbles ID/EX when the instruction in ID reads the destination of a load that
// is still in EX, since forwarding cannot cover that case.
// Ports:
// - clk, reset_n: clock and asynchronous active-low reset.
// - mem_ready: 0 freezes the whole pipeline, so it also forces stall.
// - id_*: the instruction currently in ID (sources, destination, control bits).
// - ex_flush: taken branch/jump in EX; kills IF/ID and overrides any load-use stall.
// - stall, id_ex_bubble: hazard controls.
// - pending_mask: registers with an outstanding write in EX/MEM/WB.
// - stall_count: saturating count of load-use stall cycles.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned ADDR_W   = SbAddrW,
  parameter int unsigned NUM_REGS = SbNumRegs,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                mem_ready,
  input  logic                id_valid,
  input  logic [ADDR_W-1:0]   id_rs,
  input  logic [ADDR_W-1:0]   id_rt,
  input  logic                id_use_rs,
  input  logic                id_use_rt,
  input  logic [ADDR_W-1:0]   id_dest,
  input  logic                id_regwrite,
  input  logic                id_memread,
  input  logic                ex_flush,
  output logic                stall,
  output logic                id_ex_bubble,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic [CNT_W-1:0]    stall_count
);

  logic [SbEntryW-1:0] ex_q, mem_q, wb_q, ex_d;
  logic [SbAddrW-1:0]  ex_dest;
  logic                load_use;
  logic                ex_bubble;
  logic [CNT_W-1:0]    stall_count_d, stall_count_q;

  assign ex_dest = ex_q[SbDestLsb +: SbAddrW];

  // Only a load still in EX needs a stall; from MEM onward its data can be forwarded.
  always_comb begin
    load_use = id_valid & ex_q[SbValidBit] & ex_q[SbMrBit] & ex_q[SbRwBit] & ~ex_flush &
               ((id_use_rs & (id_rs == ex_dest)) | (id_use_rt & (id_rt == ex_dest)));
  end

  assign stall        = load_use | ~mem_ready;
  assign id_ex_bubble = (load_use | ex_flush) & mem_ready;

  assign ex_d      = {1'b1, id_dest, id_regwrite, id_memread};
  assign ex_bubble = load_use | ex_flush | ~id_valid;

  hazard_stage_reg u_stage_ex (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .en_i     (mem_ready),
    .bubble_i (ex_bubble),
    .d_i      (ex_d),
    .q_o      (ex_q)
  );

  hazard_stage_reg u_stage_mem (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .en_i     (mem_ready),
    .bubble_i (1'b0),
    .d_i      (ex_q),
    .q_o      (mem_q)
  );

  hazard_stage_reg u_stage_wb (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .en_i     (mem_ready),
    .bubble_i (1'b0),
    .d_i      (mem_q),
    .q_o      (wb_q)
  );

  always_comb begin
    pending_mask = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      pending_mask[r] = sb_writes(ex_q, SbAddrW'(r)) | sb_writes(mem_q, SbAddrW'(r)) |
                        sb_writes(wb_q, SbAddrW'(r));
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (load_use && mem_ready && !(&stall_count_q)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  typedef struct packed {
    logic       v;
    logic [1:0] rs;
    logic [1:0] rt;
    logic       urs;
    logic       urt;
    logic [1:0] dest;
    logic       rw;
    logic       mr;
  } instr_t;

  typedef struct packed {
    logic        stall;
    logic        bubble;
    logic [3:0]  mask;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n, mem_ready, id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread;
  logic        ex_flush;
  logic [1:0]  id_rs, id_rt, id_dest;
  logic        stall, id_ex_bubble, stall2, bubble2;
  logic [3:0]  pending_mask, mask2;
  logic [15:0] stall_count;
  logic [1:0]  stall_count2;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];

  // Reference model state: index 0 = EX, 1 = MEM, 2 = WB
  bit       m_v[3];
  bit [1:0] m_d[3];
  bit       m_rw[3];
  bit       m_mr[3];
  int       m_cnt, m_cnt2;

  always #5 clk = ~clk;

  hazard_scoreboard u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mem_ready    (mem_ready),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_dest      (id_dest),
    .id_regwrite  (id_regwrite),
    .id_memread   (id_memread),
    .ex_flush     (ex_flush),
    .stall        (stall),
    .id_ex_bubble (id_ex_bubble),
    .pending_mask (pending_mask),
    .stall_count  (stall_count)
  );

  hazard_scoreboard #(.CNT_W(2)) u_dut_sat (
    .clk          (clk),
    .reset_n      (reset_n),
    .mem_ready    (mem_ready),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_dest      (id_dest),
    .id_regwrite  (id_regwrite),
    .id_memread   (id_memread),
    .ex_flush     (ex_flush),
    .stall        (stall2),
    .id_ex_bubble (bubble2),
    .pending_mask (mask2),
    .stall_count  (stall_count2)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic instr_t i_nop();
    return '0;
  endfunction

  function automatic instr_t i_lw(input logic [1:0] d);
    return '{v: 1'b1, rs: 2'd0, rt: 2'd0, urs: 1'b1, urt: 1'b0, dest: d, rw: 1'b1, mr: 1'b1};
  endfunction

  function automatic instr_t i_add(input logic [1:0] d, input logic [1:0] s, input logic [1:0] t);
    return '{v: 1'b1, rs: s, rt: t, urs: 1'b1, urt: 1'b1, dest: d, rw: 1'b1, mr: 1'b0};
  endfunction

  function automatic bit model_lu();
    return id_valid && m_v[0] && m_mr[0] && m_rw[0] && !ex_flush &&
           ((id_use_rs && id_rs == m_d[0]) || (id_use_rt && id_rt == m_d[0]));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_v[i] = 0; m_d[i] = 0; m_rw[i] = 0; m_mr[i] = 0;
    end
    m_cnt  = 0;
    m_cnt2 = 0;
  endtask

  always @(posedge clk) begin
    if (reset_n && mem_ready) begin
      bit lu;
      lu = model_lu();
      for (int i = 2; i > 0; i--) begin
        m_v[i] = m_v[i-1]; m_d[i] = m_d[i-1]; m_rw[i] = m_rw[i-1]; m_mr[i] = m_mr[i-1];
      end
      if (lu || ex_flush || !id_valid) begin
        m_v[0] = 0; m_d[0] = 0; m_rw[0] = 0; m_mr[0] = 0;
      end else begin
        m_v[0] = 1; m_d[0] = id_dest; m_rw[0] = id_regwrite; m_mr[0] = id_memread;
      end
      if (lu) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
  end

  task automatic push_expected();
    exp_t e;
    bit lu;
    lu       = model_lu();
    e.stall  = lu || !mem_ready;
    e.bubble = (lu || ex_flush) && mem_ready;
    e.mask   = '0;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 3; i++) begin
        if (m_v[i] && m_rw[i] && m_d[i] == 2'(r)) e.mask[r] = 1'b1;
      end
    end
    e.cnt  = 16'(m_cnt);
    e.cnt2 = 2'(m_cnt2);
    exp_q.push_back(e);
  endtask

  task automatic compare_outputs();
    exp_t e;
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check_eq("stall", stall, e.stall);
    check_eq("bubble", id_ex_bubble, e.bubble);
    check_eq("mask", pending_mask, e.mask);
    check_eq("count", stall_count, e.cnt);
    check_eq("count_sat", stall_count2, e.cnt2);
  endtask

  // Apply one ID instruction for a cycle and check outputs before the next edge.
  task automatic cyc(input instr_t in, input logic flush, input logic rdy);
    @(negedge clk);
    id_valid = in.v; id_rs = in.rs; id_rt = in.rt; id_use_rs = in.urs; id_use_rt = in.urt;
    id_dest = in.dest; id_regwrite = in.rw; id_memread = in.mr;
    ex_flush = flush; mem_ready = rdy;
    #1;
    push_expected();
    compare_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    model_clear();
    #1;
    check_eq("rst_stall", stall, 1'b0);
    check_eq("rst_mask", pending_mask, 4'b0000);
    check_eq("rst_count", stall_count, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; mem_ready = 1'b0; ex_flush = 1'b0;
    id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_dest = 0; id_regwrite = 0; id_memread = 0;
    model_clear();
    #2;
    check_eq("rst_stall_notready", stall, 1'b1);
    check_eq("rst_bubble_notready", id_ex_bubble, 1'b0);
    mem_ready = 1'b1;
    #1;
    check_eq("rst_stall_ready", stall, 1'b0);
    do_reset();

    // Load-use: exactly one stall cycle.
    cyc(i_lw(2'd1), 0, 1);
    cyc(i_add(2'd2, 2'd1, 2'd3), 0, 1);
    check_eq("t1_stall", stall, 1'b1);
    check_eq("t1_bubble", id_ex_bubble, 1'b1);
    cyc(i_add(2'd2, 2'd1, 2'd3), 0, 1);
    check_eq("t1_release", stall, 1'b0);
    check_eq("t1_count", stall_count, 16'd1);
    cyc(i_nop(), 0, 1);
    check_eq("t1_mask", pending_mask, 4'b0110);
    repeat (3) cyc(i_nop(), 0, 1);

    // Load followed by independent op, use two instructions later: no stall.
    do_reset();
    cyc(i_lw(2'd1), 0, 1);
    cyc(i_add(2'd2, 2'd3, 2'd0), 0, 1);
    check_eq("t2_mask_ex", pending_mask, 4'b0010);
    cyc(i_add(2'd3, 2'd1, 2'd1), 0, 1);
    check_eq("t2_nostall", stall, 1'b0);
    cyc(i_nop(), 0, 1);
    cyc(i_nop(), 0, 1);
    check_eq("t2_r1_clear", pending_mask[1], 1'b0);
    check_eq("t2_count", stall_count, 16'd0);
    repeat (3) cyc(i_nop(), 0, 1);

    // Flush beats load-use.
    do_reset();
    cyc(i_lw(2'd1), 0, 1);
    cyc(i_add(2'd2, 2'd1, 2'd0), 1, 1);
    check_eq("t3_stall", stall, 1'b0);
    check_eq("t3_bubble", id_ex_bubble, 1'b1);
    cyc(i_nop(), 0, 1);
    check_eq("t3_mask", pending_mask, 4'b0010);
    check_eq("t3_count", stall_count, 16'd0);

    // Memory not ready for 3 cycles with a load in MEM.
    do_reset();
    cyc(i_lw(2'd2), 0, 1);
    cyc(i_nop(), 0, 1);
    repeat (3) begin
      cyc(i_add(2'd3, 2'd2, 2'd2), 0, 0);
      check_eq("t4_stall", stall, 1'b1);
      check_eq("t4_bubble", id_ex_bubble, 1'b0);
      check_eq("t4_mask", pending_mask, 4'b0100);
    end
    cyc(i_add(2'd3, 2'd2, 2'd2), 0, 1);
    check_eq("t4_released", stall, 1'b0);
    cyc(i_nop(), 0, 1);
    check_eq("t4_adv1", pending_mask, 4'b1100);
    cyc(i_nop(), 0, 1);
    check_eq("t4_adv2", pending_mask, 4'b1000);

    // Saturation of the narrow counter.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(i_lw(2'd1), 0, 1);
      cyc(i_add(2'd2, 2'd1, 2'd1), 0, 1);
      cyc(i_add(2'd2, 2'd1, 2'd1), 0, 1);
      check_eq("t5_sat", stall_count2, (i + 1 > 3) ? 32'd3 : 32'(i + 1));
    end
    check_eq("t5_count", stall_count, 16'd5);

    // Asynchronous reset in the middle of a stall.
    cyc(i_lw(2'd1), 0, 1);
    cyc(i_add(2'd2, 2'd1, 2'd1), 0, 1);
    check_eq("t6_pre_stall", stall, 1'b1);
    #1;
    reset_n = 1'b0;
    model_clear();
    #1;
    check_eq("t6_stall", stall, 1'b0);
    check_eq("t6_mask", pending_mask, 4'b0000);
    check_eq("t6_count", stall_count, 16'd0);
    check_eq("t6_count_sat", stall_count2, 2'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(i_add(2'd2, 2'd1, 2'd1), 0, 1);
    check_eq("t6_no_spurious", stall, 1'b0);
    repeat (3) cyc(i_add(2'd3, 2'd2, 2'd1), 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
